// File: rtl/rl_lj_pair_scheduler_if.sv
// Handshake/bus bundle between the pair scheduler, the position memory,
// the LJ force pipeline and the downstream accumulator.
interface rl_lj_pair_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W:0]   num_particles;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_ref_addr;
    logic [ADDR_W-1:0] rd_nb_addr;
    logic              lj_ivalid;
    logic              lj_oready;
    logic              lj_ovalid;
    logic              out_valid;
    logic [ADDR_W-1:0] out_ref_id;
    logic [ADDR_W-1:0] out_nb_id;
    logic              out_last_ref;
    logic              sync_err;
    logic [31:0]       pair_count;
    logic [31:0]       stall_count;

    modport master (
        output start, num_particles, lj_oready, lj_ovalid,
        input  busy, done, rd_en, rd_ref_addr, rd_nb_addr, lj_ivalid,
               out_valid, out_ref_id, out_nb_id, out_last_ref, sync_err,
               pair_count, stall_count
    );

    modport slave (
        input  start, num_particles, lj_oready, lj_ovalid,
        output busy, done, rd_en, rd_ref_addr, rd_nb_addr, lj_ivalid,
               out_valid, out_ref_id, out_nb_id, out_last_ref, sync_err,
               pair_count, stall_count
    );
endinterface

// File: rtl/rl_lj_pair_scheduler.sv
// Walks every i<j pair of one cell into the stall-free LJ force pipeline and tags results.
// Optional macro RL_LJ_SCHED_PERF_CNT_EN adds saturating pair/stall counters.
module rl_lj_pair_scheduler #(
    parameter int ADDR_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int LJ_LATENCY = 24
) (
    input  logic                  clock,
    input  logic                  resetn,
    rl_lj_pair_scheduler_if.slave bus
);
    localparam int DEPTH = MEM_LAT + LJ_LATENCY;
    localparam int CNT_W = $clog2(DEPTH + 1) + 1;
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(2'd1);
    localparam logic [ADDR_W-1:0] TWO_A = ADDR_W'(2'd2);
    localparam logic [ADDR_W:0]   ONE_N = (ADDR_W + 1)'(2'd1);
    localparam logic [ADDR_W:0]   TWO_N = (ADDR_W + 1)'(2'd2);
    localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(2'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] ref_id;
        logic [ADDR_W-1:0] nb_id;
        logic              last;
    } tag_t;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    tag_t              tag_q [1:DEPTH];
    tag_t              push_s, tail_s;
    logic              rd_en_s, clr_s, last_j_s, last_i_s, dec_s, drain_empty_s;
    logic              sync_q, mismatch_s;

    assign last_j_s      = ({1'b0, j_q} == (n_q - ONE_N));
    assign last_i_s      = ({1'b0, i_q} == (n_q - TWO_N));
    assign dec_s         = bus.lj_ovalid && (inflight_q != {CNT_W{1'b0}});
    // DRAIN looks at this cycle's retirement so done lands the cycle after the last result
    assign drain_empty_s = (inflight_q == {CNT_W{1'b0}}) || ((inflight_q == ONE_C) && bus.lj_ovalid);

    // Next-state, pair-index advance and read strobe
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        rd_en_s = 1'b0;
        clr_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d   = bus.num_particles;
                    i_d   = {ADDR_W{1'b0}};
                    j_d   = ONE_A;
                    clr_s = 1'b1;
                    if (bus.num_particles >= TWO_N) state_d = S_ISSUE;
                    else                            state_d = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (bus.lj_oready) begin
                    rd_en_s = 1'b1;
                    if (last_j_s && last_i_s) begin
                        state_d = S_DRAIN;
                    end else if (last_j_s) begin
                        i_d = i_q + ONE_A;
                        j_d = i_q + TWO_A;
                    end else begin
                        j_d = j_q + ONE_A;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (drain_empty_s) state_d = S_DONE;
                else               state_d = S_DRAIN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // In-flight pair count: issues in, results out, both in one cycle
    always_comb begin
        inflight_d = inflight_q;
        if (rd_en_s && !dec_s)      inflight_d = inflight_q + ONE_C;
        else if (!rd_en_s && dec_s) inflight_d = inflight_q - ONE_C;
        else                        inflight_d = inflight_q;
    end

    // Tag entering the delay line this cycle
    always_comb begin
        push_s = '{valid: 1'b0, ref_id: {ADDR_W{1'b0}}, nb_id: {ADDR_W{1'b0}}, last: 1'b0};
        if (rd_en_s) push_s = '{valid: 1'b1, ref_id: i_q, nb_id: j_q, last: last_j_s};
        else         push_s = '{valid: 1'b0, ref_id: {ADDR_W{1'b0}}, nb_id: {ADDR_W{1'b0}}, last: 1'b0};
    end

    // Control state, pair indices, in-flight count and sticky sync error
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            n_q        <= {(ADDR_W + 1){1'b0}};
            i_q        <= {ADDR_W{1'b0}};
            j_q        <= {ADDR_W{1'b0}};
            inflight_q <= {CNT_W{1'b0}};
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            i_q        <= i_d;
            j_q        <= j_d;
            inflight_q <= inflight_d;
            if (clr_s)           sync_q <= 1'b0;
            else if (mismatch_s) sync_q <= 1'b1;
            else                 sync_q <= sync_q;
        end
    end

    // Tag delay line, free-running because the LJ pipeline never stalls
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 1; k <= DEPTH; k++) tag_q[k] <= '0;
        end else begin
            tag_q[1] <= push_s;
            for (int k = 2; k <= DEPTH; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign tail_s           = tag_q[DEPTH];
    assign mismatch_s       = tail_s.valid ^ bus.lj_ovalid;
    assign bus.busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign bus.done         = (state_q == S_DONE);
    assign bus.rd_en        = rd_en_s;
    assign bus.rd_ref_addr  = i_q;
    assign bus.rd_nb_addr   = j_q;
    assign bus.lj_ivalid    = tag_q[MEM_LAT].valid;
    assign bus.out_valid    = bus.lj_ovalid;
    assign bus.out_ref_id   = bus.lj_ovalid ? tail_s.ref_id : {ADDR_W{1'b0}};
    assign bus.out_nb_id    = bus.lj_ovalid ? tail_s.nb_id  : {ADDR_W{1'b0}};
    assign bus.out_last_ref = bus.lj_ovalid & tail_s.last;
    assign bus.sync_err     = sync_q | mismatch_s;

`ifdef RL_LJ_SCHED_PERF_CNT_EN
    logic [31:0] pair_cnt_q, stall_cnt_q;

    // Saturating performance counters, restarted with each accepted cell
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pair_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else if (clr_s) begin
            pair_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (rd_en_s && (pair_cnt_q != 32'hFFFF_FFFF)) pair_cnt_q <= pair_cnt_q + 32'd1;
            else                                          pair_cnt_q <= pair_cnt_q;
            if ((state_q == S_ISSUE) && !bus.lj_oready && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            else
                stall_cnt_q <= stall_cnt_q;
        end
    end

    assign bus.pair_count  = pair_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.pair_count  = 32'd0;
    assign bus.stall_count = 32'd0;
`endif
endmodule

// File: doc/rl_lj_pair_scheduler.md
# rl_lj_pair_scheduler

Sequencer for the range-limited Lennard-Jones first-order force pipeline (`RL_LJ_Evaluation_1st_Order`, fixed 24-cycle latency). For one cell of N particles it walks every unique pair (i, j), with i < j, in half-shell order. It drives read addresses to the position memory and asserts the pipeline's `ivalid` when the position data arrives. A tag delay line carries (ref_id, nb_id, last_of_ref) alongside each pair, so the downstream force accumulator can attribute every `forceoutput_*` result.

## Interface
- `ADDR_W`, 8, particle index width; N ≤ 2^ADDR_W.
- `MEM_LAT`, 1, position-memory read latency in cycles (≥1).
- `LJ_LATENCY`, 24, LJ pipeline latency from `ivalid` to `ovalid`.

Ports (clock and reset first):
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a cell; sampled only in IDLE.
- `num_particles`  in  ADDR_W+1  N; sampled with `start`.
- `busy`  out  1  high in ISSUE and DRAIN.
- `done`  out  1  one-cycle pulse when all pairs have drained.
- `rd_en`  out  1  position-memory read strobe.
- `rd_ref_addr`, `rd_nb_addr`  out  ADDR_W  i and j read addresses.
- `lj_ivalid`  out  1  to the pipeline `ivalid`; `rd_en` delayed by MEM_LAT.
- `lj_oready`  in  1  pipeline ready; gates address issue.
- `lj_ovalid`  in  1  pipeline `ovalid`.
- `out_valid`  out  1  equals `lj_ovalid`.
- `out_ref_id`, `out_nb_id`  out  ADDR_W  pair tag aligned with `forceoutput_*`.
- `out_last_ref`  out  1  high on the last pair of the current reference i (j = N−1).
- `sync_err`  out  1  sticky: tag-valid and `lj_ovalid` disagree.
- `pair_count`  out  32  pairs issued since `start`.
- `stall_count`  out  32  cycles spent in ISSUE with `lj_oready` low.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start` high: latch N, set i=0 and j=1, clear `sync_err` and the counters.
  - Go to ISSUE if N ≥ 2, otherwise go to DRAIN.
- ISSUE: each cycle with `lj_oready`=1:
  - Assert `rd_en` with (i, j) and push tag {1, i, j, j==N−1} into the delay line.
  - Advance j. When j reaches N−1: set i←i+1, j←i+2.
  - After issuing (N−2, N−1), go to DRAIN.
- ISSUE with `lj_oready`=0: no issue, pair indices hold, `stall_count` increments.
- DRAIN: wait until the in-flight counter is 0, then go to DONE.
  - The in-flight counter increments on `rd_en` and decrements on `out_valid`; it is updated for both in the same cycle.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Tag delay line:
  - Depth MEM_LAT+LJ_LATENCY; it shifts every cycle and is never stalled, because the LJ pipeline is stall-free.
  - `lj_ivalid` is the valid bit tapped at stage MEM_LAT.
  - `out_*` are the final stage, combinationally qualified by `lj_ovalid`.
- `sync_err` sets when the final-stage valid ≠ `lj_ovalid`. It holds until the next accepted `start` or reset.
- The pipeline accepts the data returned for an issued address regardless of the `lj_oready` value in the return cycle; `lj_oready` is sampled only at address issue.
- Total pairs = N(N−1)/2.

## Timing
- Reset (asynchronous): state=IDLE; all outputs 0, counters 0, delay line cleared.
- Reset mid-operation abandons the cell: in-flight tags are discarded and no `done` is produced.
- `start` sampled at cycle 0:
  - First `rd_en` at cycle 1.
  - First `lj_ivalid` at 1+MEM_LAT.
  - First `out_valid` at 1+MEM_LAT+LJ_LATENCY (cycle 26 with defaults).
- Throughput: one pair per cycle while `lj_oready`=1.
- `done` timing: the cycle after the final `out_valid`, i.e. 1 + P + MEM_LAT + LJ_LATENCY + stall cycles, for P pairs.
- N ∈ {0,1}: IDLE→DRAIN→DONE, with `done` at cycle 2 and no `rd_en`.

## Configuration
- `RL_LJ_SCHED_PERF_CNT_EN` defined: `pair_count` and `stall_count` are implemented as 32-bit saturating counters, cleared on `start`.
- Not defined: both outputs are tied to 0 and no counter logic is instantiated.
- All other behaviour is identical in both builds.

## Test plan
- N=3, `lj_oready`=1, model pipeline of 24 cycles:
  - `rd_en` at cycles 1–3 with pairs (0,1),(0,2),(1,2).
  - `out_valid` at cycles 26–28 with `out_last_ref`=0,1,1.
  - `done` at cycle 29; `sync_err`=0.
- N=1 and N=0: `done` at cycle 2, no `rd_en`, `busy` high for cycle 1 only.
- N=4 with `lj_oready` low for cycles 3–5:
  - 6 pairs in the order (0,1)(0,2)(0,3)(1,2)(1,3)(2,3) with no gaps in the sequence.
  - `done` delayed by 3 cycles; `stall_count`=3 with the macro.
- Model drops one `lj_ovalid` → `sync_err`=1 from that cycle until the next `start`.
- Assert `resetn`=0 at cycle 10 of N=8:
  - All outputs are 0 immediately; no `done`.
  - A fresh `start` runs cleanly with 28 pairs.
- `start` pulsed during ISSUE: ignored; `pair_count`=N(N−1)/2 at `done` with the macro, and 0 without it.
